// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and guards memory handshakes with a bus timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 on ALU, wait for mem_ready
// DECODE   | branch target into ALUOut, classify instruction
// EXEC_R   | register-register ALU op or shift
// EXEC_I   | register-immediate ALU op (incl. lui)
// ALU_WB   | write ALU result to rd (R-type) or rt (I-type)
// ADDR     | effective address rs + sign-extended offset
// MEM_RD   | load data read, wait for mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store data write, wait for mem_ready
// BRANCH   | compare rs/rt, PC <= ALUOut when cmp is set
// JUMP     | j/jal/jr/jalr PC update and optional link
module multi_cycle_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       cmp,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic       lu_op,
  output logic [5:0] alu_fun,
  output logic       alu_sign,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ALU_WB = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WB = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CL_ILL, CL_R, CL_SH, CL_I, CL_MEM, CL_BR, CL_JMP
  } cls_t;

  localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                         F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                         F_PASSB = 6'b011010, F_SLL = 6'b100000, F_SRL = 6'b100001,
                         F_SRA = 6'b100011, F_EQ = 6'b110011, F_NE = 6'b110001,
                         F_LT  = 6'b110101, F_LEZ = 6'b111101, F_LTZ = 6'b111011,
                         F_GTZ = 6'b111111;

  localparam logic [15:0] LP_TIMEOUT = BUS_TIMEOUT[15:0];

  state_t      r_state;
  logic [15:0] r_wait;

  state_t      w_next;
  cls_t        w_cls;
  logic [5:0]  w_fun_r;
  logic        w_sign_r;
  logic [5:0]  w_fun_i;
  logic        w_ext_i;
  logic        w_lui;
  logic [5:0]  w_fun_b;
  logic        w_wait_st;
  logic        w_timeout;

  always_comb begin
    w_cls    = CL_ILL;
    w_fun_r  = F_ADD;
    w_sign_r = 1'b1;
    w_fun_i  = F_ADD;
    w_ext_i  = 1'b1;
    w_lui    = 1'b0;
    w_fun_b  = F_EQ;
    case (op)
      6'h00: begin
        case (funct)
          6'h00: begin w_cls = CL_SH; w_fun_r = F_SLL; end
          6'h02: begin w_cls = CL_SH; w_fun_r = F_SRL; end
          6'h03: begin w_cls = CL_SH; w_fun_r = F_SRA; end
          6'h08, 6'h09: w_cls = CL_JMP;
          6'h20: begin w_cls = CL_R; w_fun_r = F_ADD; end
          6'h21: begin w_cls = CL_R; w_fun_r = F_ADD; w_sign_r = 1'b0; end
          6'h22: begin w_cls = CL_R; w_fun_r = F_SUB; end
          6'h23: begin w_cls = CL_R; w_fun_r = F_SUB; w_sign_r = 1'b0; end
          6'h24: begin w_cls = CL_R; w_fun_r = F_AND; end
          6'h25: begin w_cls = CL_R; w_fun_r = F_OR;  end
          6'h26: begin w_cls = CL_R; w_fun_r = F_XOR; end
          6'h27: begin w_cls = CL_R; w_fun_r = F_NOR; end
          6'h2A: begin w_cls = CL_R; w_fun_r = F_LT;  end
          default: w_cls = CL_ILL;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) begin w_cls = CL_BR; w_fun_b = F_LTZ; end
      end
      6'h02, 6'h03: w_cls = CL_JMP;
      6'h04: begin w_cls = CL_BR; w_fun_b = F_EQ;  end
      6'h05: begin w_cls = CL_BR; w_fun_b = F_NE;  end
      6'h06: begin w_cls = CL_BR; w_fun_b = F_LEZ; end
      6'h07: begin w_cls = CL_BR; w_fun_b = F_GTZ; end
      6'h08, 6'h09: begin w_cls = CL_I; w_fun_i = F_ADD; end
      6'h0A: begin w_cls = CL_I; w_fun_i = F_LT; end
      6'h0C: begin w_cls = CL_I; w_fun_i = F_AND; w_ext_i = 1'b0; end
      6'h0D: begin w_cls = CL_I; w_fun_i = F_OR;  w_ext_i = 1'b0; end
      6'h0E: begin w_cls = CL_I; w_fun_i = F_XOR; w_ext_i = 1'b0; end
      6'h0F: begin w_cls = CL_I; w_fun_i = F_PASSB; w_ext_i = 1'b0; w_lui = 1'b1; end
      6'h23, 6'h2B: w_cls = CL_MEM;
      default: w_cls = CL_ILL;
    endcase
  end

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // a ready in the timeout cycle still completes the access normally
  assign w_timeout = (LP_TIMEOUT != 16'd0) && w_wait_st && !mem_ready && (r_wait == LP_TIMEOUT);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_cls)
          CL_R, CL_SH: w_next = S_EXEC_R;
          CL_I:        w_next = S_EXEC_I;
          CL_MEM:      w_next = S_ADDR;
          CL_BR:       w_next = S_BRANCH;
          CL_JMP:      w_next = S_JUMP;
          default:     w_next = S_FETCH;
        endcase
      end
      S_EXEC_R: w_next = S_ALU_WB;
      S_EXEC_I: w_next = S_ALU_WB;
      S_ADDR:   w_next = (op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: w_next = mem_ready ? S_MEM_WB : (w_timeout ? S_FETCH : S_MEM_RD);
      S_MEM_WR: w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEM_WR;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait  <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout)
        r_wait <= 16'd0;
      else if (w_wait_st && !mem_ready && (r_wait != 16'hFFFF))
        r_wait <= r_wait + 16'd1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    ext_op     = 1'b0;
    lu_op      = 1'b0;
    alu_fun    = F_ADD;
    alu_sign   = 1'b1;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        ext_op    = 1'b1;
        illegal   = (w_cls == CL_ILL);
      end
      S_EXEC_R: begin
        alu_src_a = (w_cls == CL_SH) ? 2'd2 : 2'd1;
        alu_fun   = w_fun_r;
        alu_sign  = w_sign_r;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ext_op    = w_ext_i;
        lu_op     = w_lui;
        alu_fun   = w_fun_i;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op == 6'h00) ? 2'd1 : 2'd0;
      end
      S_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'd1;
        alu_fun   = w_fun_b;
        pc_write  = cmp;
        pc_src    = 2'd1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        if (op == 6'h00) begin
          pc_src = 2'd3;
          if (funct == 6'h09) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd1;
            mem_to_reg = 2'd2;
          end
        end else begin
          pc_src = 2'd2;
          if (op == 6'h03) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
      end
      default: ;
    endcase
    if (w_timeout) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      bus_err   = 1'b1;
    end
    // strobes follow reset without waiting for a clock edge
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: expected outputs queued per step, checked mid-cycle.
module tb_multi_cycle_ctrl;

  logic       clk, reset;
  logic [5:0] op, funct;
  logic [4:0] rt;
  logic       cmp, mem_ready;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
  logic       ext_op, lu_op, alu_sign, illegal, bus_err;
  logic [5:0] alu_fun;
  logic [3:0] state;

  multi_cycle_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rt(rt), .cmp(cmp),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .lu_op(lu_op), .alu_fun(alu_fun),
    .alu_sign(alu_sign), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_ST = 0, F_PCW = 1, F_PCS = 2, F_IRW = 3, F_IORD = 4, F_MRD = 5,
                 F_MWR = 6, F_RW = 7, F_RDST = 8, F_M2R = 9, F_A = 10, F_B = 11,
                 F_EXT = 12, F_LU = 13, F_FUN = 14, F_SIGN = 15, F_ILL = 16, F_BERR = 17;

  typedef struct {
    string       tag;
    int          fid;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic logic [15:0] get_f(input int fid);
    case (fid)
      F_ST:   return 16'(state);
      F_PCW:  return 16'(pc_write);
      F_PCS:  return 16'(pc_src);
      F_IRW:  return 16'(ir_write);
      F_IORD: return 16'(iord);
      F_MRD:  return 16'(mem_read);
      F_MWR:  return 16'(mem_write);
      F_RW:   return 16'(reg_write);
      F_RDST: return 16'(reg_dst);
      F_M2R:  return 16'(mem_to_reg);
      F_A:    return 16'(alu_src_a);
      F_B:    return 16'(alu_src_b);
      F_EXT:  return 16'(ext_op);
      F_LU:   return 16'(lu_op);
      F_FUN:  return 16'(alu_fun);
      F_SIGN: return 16'(alu_sign);
      F_ILL:  return 16'(illegal);
      F_BERR: return 16'(bus_err);
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic ex(input string tag, input int fid, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.fid = fid; e.val = v;
    q.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    logic [15:0] obs;
    while (q.size() != 0) begin
      e = q.pop_front();
      obs = get_f(e.fid);
      n_checks++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk();
    #2;
    check_q();
  endtask

  task automatic nxt(input logic mr, input logic c);
    @(negedge clk);
    mem_ready = mr;
    cmp = c;
  endtask

  task automatic ir(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    op = o; funct = f; rt = r;
  endtask

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; rt = 5'd0; cmp = 1'b0; mem_ready = 1'b1;
    ex("rst_st", F_ST, 0); ex("rst_mrd", F_MRD, 0); ex("rst_irw", F_IRW, 0);
    ex("rst_pcw", F_PCW, 0); ex("rst_sign", F_SIGN, 1); ex("rst_fun", F_FUN, 0); chk();
    nxt(1, 0);
    ex("rst2_mrd", F_MRD, 0); ex("rst2_irw", F_IRW, 0); ex("rst2_st", F_ST, 0); chk();

    // add
    nxt(1, 0); reset = 1'b1; ir(6'h00, 6'h20, 0);
    ex("f_st", F_ST, 0); ex("f_mrd", F_MRD, 1); ex("f_irw", F_IRW, 1); ex("f_pcw", F_PCW, 1);
    ex("f_fun", F_FUN, 0); ex("f_a", F_A, 0); ex("f_b", F_B, 1); ex("f_iord", F_IORD, 0); chk();
    nxt(1, 0); ex("add_d_st", F_ST, 1); ex("d_b", F_B, 3); ex("d_ext", F_EXT, 1); chk();
    nxt(1, 0); ex("add_x_st", F_ST, 2); ex("add_fun", F_FUN, 0); ex("add_a", F_A, 1);
    ex("add_b", F_B, 0); ex("add_sign", F_SIGN, 1); chk();
    nxt(1, 0); ex("add_wb_st", F_ST, 4); ex("add_rw", F_RW, 1); ex("add_rdst", F_RDST, 1);
    ex("add_m2r", F_M2R, 0); chk();

    // sll
    nxt(1, 0); ir(6'h00, 6'h00, 0); ex("sll_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("sll_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("sll_x_st", F_ST, 2); ex("sll_a", F_A, 2); ex("sll_fun", F_FUN, 6'b100000); chk();
    nxt(1, 0); ex("sll_wb_st", F_ST, 4); chk();

    // beq, cmp toggled inside BRANCH
    nxt(1, 1); ir(6'h04, 6'h00, 0); ex("beq_f_st", F_ST, 0); chk();
    nxt(1, 1); ex("beq_d_st", F_ST, 1); ex("beq_d_pcw", F_PCW, 0); chk();
    nxt(1, 1); ex("beq_st", F_ST, 9); ex("beq_fun", F_FUN, 6'b110011); ex("beq_pcw1", F_PCW, 1);
    ex("beq_pcs", F_PCS, 1); ex("beq_a", F_A, 1); ex("beq_b", F_B, 0); chk();
    cmp = 1'b0; #1; ex("beq_pcw0", F_PCW, 0); check_q();

    // bltz
    nxt(1, 0); ir(6'h01, 6'h00, 0); ex("bltz_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("bltz_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("bltz_st", F_ST, 9); ex("bltz_fun", F_FUN, 6'b111011); ex("bltz_pcw", F_PCW, 0); chk();

    // lw with 3 wait cycles
    nxt(1, 0); ir(6'h23, 6'h00, 0); ex("lw_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("lw_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("lw_a_st", F_ST, 5); ex("lw_a_a", F_A, 1); ex("lw_a_b", F_B, 2); ex("lw_a_ext", F_EXT, 1); chk();
    for (int k = 0; k < 3; k++) begin
      nxt(0, 0); ex("lw_wait_st", F_ST, 6); ex("lw_wait_mrd", F_MRD, 1); ex("lw_wait_iord", F_IORD, 1);
      ex("lw_wait_berr", F_BERR, 0); chk();
    end
    nxt(1, 0); ex("lw_rdy_st", F_ST, 6); ex("lw_rdy_mrd", F_MRD, 1); chk();
    nxt(1, 0); ex("lw_wb_st", F_ST, 7); ex("lw_wb_rw", F_RW, 1); ex("lw_wb_m2r", F_M2R, 1);
    ex("lw_wb_rdst", F_RDST, 0); chk();

    // sw with bus timeout after 4 wait cycles
    nxt(1, 0); ir(6'h2B, 6'h00, 0); ex("sw_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("sw_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("sw_a_st", F_ST, 5); chk();
    for (int k = 0; k < 4; k++) begin
      nxt(0, 0); ex("sw_wait_st", F_ST, 8); ex("sw_wait_mwr", F_MWR, 1); ex("sw_wait_iord", F_IORD, 1);
      ex("sw_wait_berr", F_BERR, 0); chk();
    end
    nxt(0, 0); ex("sw_to_st", F_ST, 8); ex("sw_to_berr", F_BERR, 1); ex("sw_to_mwr", F_MWR, 0); chk();

    // fetch waits to the timeout count, ready arrives in that cycle; then illegal opcode
    nxt(0, 0); ir(6'h3F, 6'h00, 0); ex("fw_st", F_ST, 0); ex("fw_berr", F_BERR, 0);
    ex("fw_mrd", F_MRD, 1); ex("fw_irw", F_IRW, 0); chk();
    for (int k = 0; k < 3; k++) begin
      nxt(0, 0); ex("fw_wait_st", F_ST, 0); ex("fw_wait_berr", F_BERR, 0); ex("fw_wait_pcw", F_PCW, 0); chk();
    end
    nxt(1, 0); ex("fw_tie_st", F_ST, 0); ex("fw_tie_berr", F_BERR, 0); ex("fw_tie_irw", F_IRW, 1); chk();
    nxt(1, 0); ex("ill_st", F_ST, 1); ex("ill_pulse", F_ILL, 1); chk();
    nxt(1, 0); ir(6'h03, 6'h00, 0); ex("ill_after_st", F_ST, 0); ex("ill_after", F_ILL, 0); chk();

    // jal
    nxt(1, 0); ex("jal_d_st", F_ST, 1); ex("jal_d_ill", F_ILL, 0); chk();
    nxt(1, 0); ex("jal_st", F_ST, 10); ex("jal_pcw", F_PCW, 1); ex("jal_pcs", F_PCS, 2);
    ex("jal_rw", F_RW, 1); ex("jal_rdst", F_RDST, 2); ex("jal_m2r", F_M2R, 2); chk();

    // jr
    nxt(1, 0); ir(6'h00, 6'h08, 0); ex("jr_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("jr_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("jr_st", F_ST, 10); ex("jr_pcw", F_PCW, 1); ex("jr_pcs", F_PCS, 3); ex("jr_rw", F_RW, 0); chk();

    // ori
    nxt(1, 0); ir(6'h0D, 6'h00, 0); ex("ori_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("ori_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("ori_st", F_ST, 3); ex("ori_a", F_A, 1); ex("ori_b", F_B, 2); ex("ori_ext", F_EXT, 0);
    ex("ori_fun", F_FUN, 6'b011110); ex("ori_lu", F_LU, 0); chk();
    nxt(1, 0); ex("ori_wb_st", F_ST, 4); ex("ori_wb_rw", F_RW, 1); ex("ori_wb_rdst", F_RDST, 0); chk();

    // reset asserted in the middle of a store
    nxt(1, 0); ir(6'h2B, 6'h00, 0); ex("swr_f_st", F_ST, 0); chk();
    nxt(1, 0); ex("swr_d_st", F_ST, 1); chk();
    nxt(1, 0); ex("swr_a_st", F_ST, 5); chk();
    nxt(0, 0); ex("swr_w1", F_MWR, 1); chk();
    nxt(0, 0); ex("swr_w2", F_MWR, 1); chk();
    #1; reset = 1'b0; #1;
    ex("swr_async_mwr", F_MWR, 0); ex("swr_async_st", F_ST, 0); ex("swr_async_iord", F_IORD, 0); check_q();
    nxt(0, 0); ex("swr_rst_mwr", F_MWR, 0); ex("swr_rst_mrd", F_MRD, 0); chk();
    nxt(0, 0); reset = 1'b1; ex("rel_st", F_ST, 0); ex("rel_mrd", F_MRD, 1); ex("rel_berr", F_BERR, 0); chk();
    for (int k = 0; k < 3; k++) begin
      nxt(0, 0); ex("rel_wait_berr", F_BERR, 0); chk();
    end
    nxt(0, 0); ex("rel_to_berr", F_BERR, 1); ex("rel_to_mrd", F_MRD, 0); ex("rel_to_st", F_ST, 0); chk();
    nxt(1, 0); ex("rel_ok_berr", F_BERR, 0); ex("rel_ok_irw", F_IRW, 1); chk();
    nxt(1, 0); ex("rel_ok_st", F_ST, 1); chk();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
